// File: rtl/hnf_sf_assoc.sv
// hnf_sf_assoc: set-associative snoop filter behind the HN-F POCQ head.
// Tracks the RN-Fs that hold each line using a per-entry sharer vector
// and a coarse I/S/U state. One request is held in S1. The response reports
// the pre-update directory view, the RNs to invalidate-snoop, and any victim
// that needs back-invalidation. The directory is updated only when the
// response is consumed.
//
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   req_valid/ready              request handshake
//   req_addr, req_op, req_src    line address, opcode (0 LOOKUP, 1 RS, 2 RU, 3 EVICT), requester
//   resp_valid/ready             response handshake
//   resp_hit, resp_way           hit flag, and the hit way or allocation way
//   resp_state, resp_vec         pre-update state and sharers (0 on miss)
//   resp_snp_vec                 RNs to invalidate-snoop (READ_UNIQUE only)
//   resp_victim_valid/addr/vec   replaced valid entry, for back-invalidation
module hnf_sf_assoc #(
  parameter int ADDR_W   = 48,
  parameter int OFFSET_W = 6,
  parameter int SET_W    = 7,
  parameter int WAYS     = 4,
  parameter int NUM_RN   = 4,
  localparam int WAY_W   = $clog2(WAYS),
  localparam int RN_W    = $clog2(NUM_RN),
  localparam int TAG_W   = ADDR_W - OFFSET_W - SET_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_op,
  input  logic [RN_W-1:0]   req_src,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_hit,
  output logic [WAY_W-1:0]  resp_way,
  output logic [1:0]        resp_state,
  output logic [NUM_RN-1:0] resp_vec,
  output logic [NUM_RN-1:0] resp_snp_vec,
  output logic              resp_victim_valid,
  output logic [ADDR_W-1:0] resp_victim_addr,
  output logic [NUM_RN-1:0] resp_victim_vec
);

  localparam int SETS = 1 << SET_W;

  localparam logic [1:0] OP_LOOKUP = 2'd0;
  localparam logic [1:0] OP_RS     = 2'd1;
  localparam logic [1:0] OP_RU     = 2'd2;
  localparam logic [1:0] OP_EVICT  = 2'd3;

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_U = 2'd2;

  logic [WAYS-1:0]   mem_valid [SETS];
  logic [TAG_W-1:0]  mem_tag   [SETS][WAYS];
  logic [1:0]        mem_state [SETS][WAYS];
  logic [NUM_RN-1:0] mem_vec   [SETS][WAYS];
  logic [WAY_W-1:0]  mem_rr    [SETS];

  logic                       s1_valid;
  logic [ADDR_W-OFFSET_W-1:0] s1_line;
  logic [1:0]                 s1_op;
  logic [RN_W-1:0]            s1_src;

  logic [TAG_W-1:0]  s1_tag;
  logic [SET_W-1:0]  s1_set;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  use_way;
  logic              alloc_op;
  logic              victim;
  logic [NUM_RN-1:0] src_oh;
  logic [NUM_RN-1:0] cur_vec;
  logic              fire;
  logic              wr_en;
  logic              new_valid;
  logic [NUM_RN-1:0] new_vec;
  logic [1:0]        new_state;
  logic              rr_bump;

  // Offset bits of the request address carry no information for a line-based directory.
  logic unused_offset;
  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  assign req_ready  = !s1_valid || resp_ready;
  assign resp_valid = s1_valid;
  assign fire       = s1_valid && resp_ready;

  assign s1_tag = s1_line[ADDR_W-OFFSET_W-1 -: TAG_W];
  assign s1_set = s1_line[SET_W-1:0];
  assign src_oh = NUM_RN'(1) << s1_src;

  // Scan from the top way down so that the lowest matching/invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mem_valid[s1_set][w] && (mem_tag[s1_set][w] == s1_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!mem_valid[s1_set][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign alloc_op = (s1_op == OP_RS) || (s1_op == OP_RU);
  assign use_way  = hit ? hit_way : (inv_found ? inv_way : mem_rr[s1_set]);
  assign victim   = s1_valid && !hit && alloc_op && !inv_found;
  assign cur_vec  = mem_vec[s1_set][use_way];

  always_comb begin
    wr_en     = 1'b0;
    new_valid = 1'b1;
    new_vec   = cur_vec;
    rr_bump   = 1'b0;
    case (s1_op)
      OP_RS: begin
        wr_en   = 1'b1;
        new_vec = hit ? (cur_vec | src_oh) : src_oh;
        rr_bump = victim;
      end
      OP_RU: begin
        wr_en   = 1'b1;
        new_vec = src_oh;
        rr_bump = victim;
      end
      OP_EVICT: begin
        wr_en     = hit;
        new_vec   = cur_vec & ~src_oh;
        new_valid = |new_vec;
      end
      default: ;
    endcase
    if (!new_valid)                  new_state = ST_I;
    else if ($countones(new_vec) == 1) new_state = ST_U;
    else                             new_state = ST_S;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (req_ready) begin
      s1_valid <= req_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (req_valid && req_ready) begin
      s1_line <= req_addr[ADDR_W-1:OFFSET_W];
      s1_op   <= req_op;
      s1_src  <= req_src;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        mem_valid[s] <= '0;
        mem_rr[s]    <= '0;
      end
    end else if (fire && wr_en) begin
      mem_valid[s1_set][use_way] <= new_valid;
      // rr is power-of-two wide, so the increment wraps mod WAYS.
      if (rr_bump) mem_rr[s1_set] <= mem_rr[s1_set] + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (fire && wr_en) begin
      mem_tag[s1_set][use_way]   <= s1_tag;
      mem_state[s1_set][use_way] <= new_state;
      mem_vec[s1_set][use_way]   <= new_vec;
    end
  end

  assign resp_hit          = s1_valid && hit;
  assign resp_way          = s1_valid ? use_way : '0;
  assign resp_state        = resp_hit ? mem_state[s1_set][use_way] : ST_I;
  assign resp_vec          = resp_hit ? cur_vec : '0;
  assign resp_snp_vec      = (s1_valid && (s1_op == OP_RU)) ? (resp_vec & ~src_oh) : '0;
  assign resp_victim_valid = victim;
  assign resp_victim_addr  = victim ? {mem_tag[s1_set][use_way], s1_set, {OFFSET_W{1'b0}}} : '0;
  assign resp_victim_vec   = victim ? cur_vec : '0;

  logic unused_lookup;
  assign unused_lookup = (s1_op == OP_LOOKUP);

endmodule

// File: tb/tb_hnf_sf_assoc.sv
module tb_hnf_sf_assoc;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [47:0] req_addr;
  logic [1:0]  req_op;
  logic [1:0]  req_src;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_hit;
  logic [1:0]  resp_way;
  logic [1:0]  resp_state;
  logic [3:0]  resp_vec;
  logic [3:0]  resp_snp_vec;
  logic        resp_victim_valid;
  logic [47:0] resp_victim_addr;
  logic [3:0]  resp_victim_vec;

  hnf_sf_assoc dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_op(req_op), .req_src(req_src),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_way(resp_way), .resp_state(resp_state), .resp_vec(resp_vec),
    .resp_snp_vec(resp_snp_vec), .resp_victim_valid(resp_victim_valid),
    .resp_victim_addr(resp_victim_addr), .resp_victim_vec(resp_victim_vec)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference directory: state is derived from the sharer count.
  bit        m_valid [128][4];
  bit [34:0] m_tag   [128][4];
  bit [3:0]  m_vec   [128][4];
  bit [1:0]  m_rr    [128];

  typedef struct packed {
    bit        hit;
    bit [1:0]  way;
    bit [1:0]  state;
    bit [3:0]  vec;
    bit [3:0]  snp;
    bit        vv;
    bit [47:0] vaddr;
    bit [3:0]  vvec;
    bit [34:0] tag;
    bit [6:0]  set;
    bit [1:0]  op;
    bit [1:0]  src;
  } exp_t;

  exp_t pend;
  bit   pend_valid;

  function automatic bit [47:0] line(input int tag, input int set);
    bit [47:0] a;
    a = (48'(tag) << 13) | (48'(set) << 6);
    return a;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 128; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 4; w++) m_valid[s][w] = 0;
    end
    pend_valid = 0;
  endtask

  function automatic exp_t predict(input bit [47:0] a, input bit [1:0] op, input bit [1:0] src);
    exp_t e;
    int inv;
    bit [3:0] oh;
    e = '0;
    e.tag = a[47:13]; e.set = a[12:6]; e.op = op; e.src = src;
    oh = 4'b0001 << src;
    inv = -1;
    for (int w = 0; w < 4; w++)
      if (!e.hit && m_valid[e.set][w] && m_tag[e.set][w] == e.tag) begin
        e.hit = 1; e.way = 2'(w);
      end
    for (int w = 3; w >= 0; w--) if (!m_valid[e.set][w]) inv = w;
    if (e.hit) begin
      e.vec   = m_vec[e.set][e.way];
      e.state = ($countones(e.vec) == 1) ? 2'd2 : 2'd1;
    end else if (inv >= 0) begin
      e.way = 2'(inv);
    end else begin
      e.way = m_rr[e.set];
      if (op == 1 || op == 2) begin
        e.vv    = 1;
        e.vaddr = {m_tag[e.set][e.way], e.set, 6'b0};
        e.vvec  = m_vec[e.set][e.way];
      end
    end
    e.snp = (op == 2) ? (e.vec & ~oh) : 4'b0;
    return e;
  endfunction

  task automatic apply(input exp_t e);
    bit [3:0] oh;
    oh = 4'b0001 << e.src;
    case (e.op)
      2'd1, 2'd2: begin
        if (e.hit && e.op == 1) m_vec[e.set][e.way] = m_vec[e.set][e.way] | oh;
        else begin
          m_valid[e.set][e.way] = 1;
          m_tag[e.set][e.way]   = e.tag;
          m_vec[e.set][e.way]   = oh;
          if (e.vv) m_rr[e.set] = m_rr[e.set] + 2'd1;
        end
      end
      2'd3: if (e.hit) begin
        m_vec[e.set][e.way] = m_vec[e.set][e.way] & ~oh;
        if (m_vec[e.set][e.way] == 0) m_valid[e.set][e.way] = 0;
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check the visible response, then
  // advance the reference model by whatever handshakes the rising edge makes.
  task automatic cyc(input bit v, input bit [47:0] a, input bit [1:0] op,
                     input bit [1:0] src, input bit rdy);
    bit fire, acc;
    req_valid = v; req_addr = a; req_op = op; req_src = src; resp_ready = rdy;
    #1;
    chk("req_ready", 64'(req_ready), 64'(!pend_valid || rdy));
    chk("resp_valid", 64'(resp_valid), 64'(pend_valid));
    if (pend_valid) begin
      chk("resp_hit", 64'(resp_hit), 64'(pend.hit));
      chk("resp_way", 64'(resp_way), 64'(pend.way));
      chk("resp_state", 64'(resp_state), 64'(pend.state));
      chk("resp_vec", 64'(resp_vec), 64'(pend.vec));
      chk("resp_snp_vec", 64'(resp_snp_vec), 64'(pend.snp));
      chk("victim_valid", 64'(resp_victim_valid), 64'(pend.vv));
      chk("victim_addr", 64'(resp_victim_addr), 64'(pend.vaddr));
      chk("victim_vec", 64'(resp_victim_vec), 64'(pend.vvec));
    end else begin
      chk("idle_hit", 64'(resp_hit), 64'd0);
      chk("idle_vec", 64'(resp_vec), 64'd0);
      chk("idle_victim", 64'(resp_victim_valid), 64'd0);
    end
    fire = pend_valid && rdy;
    acc  = v && (!pend_valid || rdy);
    @(posedge clock);
    if (fire) begin
      apply(pend);
      pend_valid = 0;
    end
    if (acc) begin
      pend = predict(a, op, src);
      pend_valid = 1;
    end
    @(negedge clock);
  endtask

  task automatic idle();
    cyc(0, 48'h0, 2'd0, 2'd0, 1);
  endtask

  task automatic do_reset();
    reset = 1; req_valid = 0; resp_ready = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
    model_clear();
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_way", 64'(resp_way), 64'd0);
    chk("rst_resp_state", 64'(resp_state), 64'd0);
    chk("rst_victim_addr", 64'(resp_victim_addr), 64'd0);
    chk("rst_snp_vec", 64'(resp_snp_vec), 64'd0);
    @(negedge clock);
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      bit [47:0] a;
      a = line($urandom_range(0, 5), $urandom_range(0, 1)) | 48'($urandom_range(0, 63));
      cyc($urandom_range(0, 3) != 0, a, 2'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    req_valid = 0; req_addr = 0; req_op = 0; req_src = 0; resp_ready = 1;
    do_reset();

    cyc(1, 48'h1000, 2'd0, 2'd0, 1);
    chk("lk0_valid", 64'(resp_valid), 64'd1);
    chk("lk0_hit", 64'(resp_hit), 64'd0);
    chk("lk0_state", 64'(resp_state), 64'd0);

    cyc(1, 48'h1000, 2'd1, 2'd0, 1);
    cyc(1, 48'h1000, 2'd1, 2'd2, 1);
    chk("rs2_hit", 64'(resp_hit), 64'd1);
    chk("rs2_state", 64'(resp_state), 64'd2);
    chk("rs2_vec", 64'(resp_vec), 64'b0001);
    cyc(1, 48'h1000, 2'd0, 2'd0, 1);
    chk("lk1_state", 64'(resp_state), 64'd1);
    chk("lk1_vec", 64'(resp_vec), 64'b0101);

    cyc(1, 48'h1000, 2'd2, 2'd1, 1);
    chk("ru_snp", 64'(resp_snp_vec), 64'b0101);
    chk("ru_vec", 64'(resp_vec), 64'b0101);
    cyc(1, 48'h1000, 2'd0, 2'd0, 1);
    chk("lk2_state", 64'(resp_state), 64'd2);
    chk("lk2_vec", 64'(resp_vec), 64'b0010);

    for (int t = 1; t <= 4; t++) cyc(1, line(t, 5), 2'd1, 2'(t % 4), 1);
    cyc(1, line(5, 5), 2'd1, 2'd1, 1);
    chk("vic1_way", 64'(resp_way), 64'd0);
    chk("vic1_valid", 64'(resp_victim_valid), 64'd1);
    chk("vic1_addr", 64'(resp_victim_addr), 64'h2140);
    chk("vic1_vec", 64'(resp_victim_vec), 64'b0010);
    cyc(1, line(6, 5), 2'd1, 2'd2, 1);
    chk("vic2_way", 64'(resp_way), 64'd1);
    chk("vic2_addr", 64'(resp_victim_addr), 64'h4140);
    chk("vic2_vec", 64'(resp_victim_vec), 64'b0100);

    cyc(1, 48'h1000, 2'd3, 2'd1, 1);
    cyc(1, 48'h1000, 2'd0, 2'd0, 1);
    chk("ev_relookup_hit", 64'(resp_hit), 64'd0);
    cyc(1, 48'h1000, 2'd3, 2'd1, 1);
    cyc(1, line(7, 5), 2'd3, 2'd0, 1);
    idle();

    cyc(1, 48'h3000, 2'd1, 2'd3, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 48'h3000, 2'd1, 2'd0, 0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    cyc(1, 48'h3000, 2'd1, 2'd0, 1);
    chk("bp_next_hit", 64'(resp_hit), 64'd1);
    chk("bp_next_vec", 64'(resp_vec), 64'b1000);
    cyc(1, 48'h3000, 2'd0, 2'd0, 1);
    chk("bp_once_vec", 64'(resp_vec), 64'b1001);
    idle();

    random_phase(500);

    req_valid = 1; req_addr = 48'h1000; req_op = 2'd1; req_src = 0;
    do_reset();
    cyc(1, 48'h3000, 2'd0, 2'd0, 1);
    chk("postrst_hit", 64'(resp_hit), 64'd0);

    random_phase(300);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hnf_sf_assoc.md
# hnf_sf_assoc

Parametrised set-associative snoop filter for the HN-F. It tracks which RN-Fs hold each cache line, using a per-entry sharer bit-vector and a coarse I/S/U state. It sits behind the POCQ head: a request is looked up, the directory is updated according to the opcode, and the response tells the HN-F whom to snoop and which victim, if any, must be back-invalidated. It supersedes the single-way, lookup-only filter with multi-way storage, allocation, round-robin replacement and in-place update.

## Interface
- ADDR_W, 48: physical address width.
- OFFSET_W, 6: line-offset bits.
- SET_W, 7: index bits. SETS = 2^SET_W.
- WAYS, 4: associativity. Power of two, ≥2. WAY_W = $clog2(WAYS).
- NUM_RN, 4: tracked RN-Fs, ≥2. RN_W = $clog2(NUM_RN).
- TAG_W, derived: ADDR_W-OFFSET_W-SET_W.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_addr  in  ADDR_W  line address. Offset bits ignored.
- req_op  in  2  0 LOOKUP, 1 READ_SHARED, 2 READ_UNIQUE, 3 EVICT.
- req_src  in  RN_W  requesting RN-F index.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumed.
- resp_hit  out  1  tag matched a valid way.
- resp_way  out  WAY_W  hit way, or allocated way on miss.
- resp_state  out  2  pre-update state: 0 I, 1 S, 2 U.
- resp_vec  out  NUM_RN  pre-update sharer vector (0 on miss).
- resp_snp_vec  out  NUM_RN  RNs to invalidate-snoop: resp_vec & ~onehot(req_src) for READ_UNIQUE, else 0.
- resp_victim_valid  out  1  a valid entry was replaced.
- resp_victim_addr  out  ADDR_W  victim line address (offset zero).
- resp_victim_vec  out  NUM_RN  victim sharers, for back-invalidation.

## Operation
- Storage per set and way: valid, tag[TAG_W], state[2], vec[NUM_RN]. Per set: rr pointer[WAY_W].
- Address split: tag = addr[ADDR_W-1 -: TAG_W], set = addr[OFFSET_W +: SET_W].
- Stage S1 is a single holding register for {addr, op, src}. req_ready = !s1_valid || resp_ready. resp_valid = s1_valid.
- While s1_valid, lookup is combinational on the arrays. Hit = a valid way with a matching tag. If several ways match, that is an error; the lowest index wins.
- Arrays and the rr pointer are written only on the response handshake (resp_valid && resp_ready), and only per the opcode rules below.
- LOOKUP: no update, no allocation. victim_valid is 0.
- READ_SHARED:
  - Hit: vec |= onehot(src). State becomes U if popcount(new vec)==1, else S.
  - Miss: allocate; vec = onehot(src); state U.
- READ_UNIQUE:
  - Hit or miss (miss allocates): vec = onehot(src); state U.
- EVICT:
  - Hit: vec &= ~onehot(src). If new vec==0, clear valid (state I). Else state U if popcount==1, else S.
  - Miss: no update.
- Allocation way:
  - Lowest-index invalid way, with victim_valid=0.
  - If all ways are valid, use way rr[set], with victim_valid=1 and victim_addr={tag,set,0}. rr[set] increments by 1, wrapping mod WAYS.
  - The rr pointer is not touched when an invalid way is used.
- Response fields are held stable while resp_valid && !resp_ready.
- Reset clears all valid bits, all rr pointers and s1_valid.
- Reset outputs: req_ready=1, resp_valid=0. All resp_* data outputs are 0.
- A request held in S1 during reset is dropped without update.

## Timing
- Latency: accepted at edge N, resp_valid high during cycle N+1.
- Throughput: one request per cycle while resp_ready=1.
- Back-to-back requests to the same set see the prior update, because the write lands on the same edge that loads the next request. No forwarding or stall is needed.
- Simultaneous response handshake and new acceptance in one cycle is legal and required for full throughput.
- A request is never lost or duplicated under backpressure.

## Test plan
- Reset, then LOOKUP 0x1000 -> resp_hit=0, state 0, vec 0, victim_valid=0, one cycle after acceptance.
- READ_SHARED 0x1000 src0, then READ_SHARED 0x1000 src2 -> second response: hit=1, state U, vec 0001. A following LOOKUP returns state S, vec 0101.
- Same line: READ_UNIQUE src1 -> resp_snp_vec=0101, vec pre 0101. A following LOOKUP returns state U, vec 0010.
- Fill one set with 4 distinct tags (WAYS=4), then a 5th tag -> allocated way 0, victim_valid=1, victim_addr = first tag's line, victim_vec = its sharers. A 6th tag victimises way 1.
- EVICT of sole sharer -> entry invalidated; re-lookup misses. EVICT on a miss -> no change.
- Hold resp_ready=0 for 3 cycles with req_valid high -> req_ready=0, response stable, no array write. Release -> the next request is accepted on the same edge, and the arrays update exactly once.
